// File: rtl/chunk_adder.sv
// Multi-cycle wide adder/subtractor: adds CHUNK bits per cycle, LSB chunk first.
// Optional subtraction is enabled by defining CHUNK_ADDER_SUBTRACT_EN.
module chunk_adder #(
    parameter int WIDTH = 1027,
    parameter int CHUNK = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = (WIDTH + CHUNK) / CHUNK;  // ceil((WIDTH+1)/CHUNK)
    localparam int EXT    = NCHUNK * CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [EXT-1:0]   a_q, a_d;
    logic [EXT-1:0]   b_q, b_d;
    logic [EXT-1:0]   sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK:0]   chunk_sum;
    logic [EXT-1:0]   sum_shift;
    logic [EXT-1:0]   b_load;
    logic             carry_load;
`ifndef CHUNK_ADDER_SUBTRACT_EN
    logic             unused_subtract;
`endif

    // Operand B and initial carry as captured on an accepted start.
    always_comb begin
`ifdef CHUNK_ADDER_SUBTRACT_EN
        b_load     = subtract ? ~(EXT'(in_b)) : EXT'(in_b);
        carry_load = subtract;
`else
        b_load          = EXT'(in_b);
        carry_load      = 1'b0;
        unused_subtract = subtract;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        chunk_sum = (CHUNK+1)'(a_q[CHUNK-1:0]) + (CHUNK+1)'(b_q[CHUNK-1:0])
                  + (CHUNK+1)'(carry_q);
        // Each new chunk enters at the top; after NCHUNK shifts chunk 0 sits at bit 0.
        sum_shift = sum_q >> CHUNK;
        sum_shift[EXT-1 -: CHUNK] = chunk_sum[CHUNK-1:0];

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ADD;
                    a_d     = EXT'(in_a);
                    b_d     = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                sum_d   = sum_shift;
                carry_d = chunk_sum[CHUNK];
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign result = sum_q[WIDTH:0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_chunk_adder.sv
// Self-checking bench for chunk_adder: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_chunk_adder;

    localparam int W   = 1027;
    localparam int LAT = 10;
    localparam int MAXWAIT = 40;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W:0]   result;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    chunk_adder #(.WIDTH(W), .CHUNK(128)) dut (
        .clk(clk), .reset(reset), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

`ifdef CHUNK_ADDER_SUBTRACT_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
        logic [W:0] ea;
        logic [W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        if (SUB_EN && sub) return ea - eb;
        return ea + eb;
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < 33; i++) v = {v[W-33:0], 32'($urandom)};
        if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(0, W - 1);
        return v;
    endfunction

    function automatic int first_diff(input logic [W:0] x, input logic [W:0] y);
        for (int i = 0; i <= W; i++) if (x[i] !== y[i]) return i;
        return -1;
    endfunction

    // Issue one operation and wait (bounded) for done; lat counts edges from the start edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output logic [W:0] res, output int lat, output logic busy0);
        @(negedge clk);
        in_a = a; in_b = b; subtract = sub; start = 1'b1;
        @(posedge clk); #1;
        busy0 = busy;
        start = 1'b0;
        in_a = rand_wide(); in_b = rand_wide(); subtract = ~sub;
        lat = 1;
        while (done !== 1'b1 && lat < MAXWAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: result_nonzero=%0b busy=%0b done=%0b, want 0/0/0",
                     result !== '0, busy, done);
        end
        start = 1'b1; in_a = '1; in_b = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: result_nonzero=%0b busy=%0b done=%0b, want 0/0/0",
                     result !== '0, busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        logic [W:0]   got;
        int           lat;
        logic         b0;

        a = '1; b = '0; b[0] = 1'b1;
        exp = '0; exp[W] = 1'b1;
        run_op(a, b, 1'b0, got, lat, b0);
        checks++;
        if (got !== exp || lat != LAT || b0 !== 1'b1) begin
            errors++;
            $display("FAIL add_max_plus_one: lat=%0d busy=%0b diffbit=%0d, want lat=%0d busy=1 result=2^%0d",
                     lat, b0, first_diff(got, exp), LAT, W);
        end

        a = '0; a[127:0] = '1;
        exp = '0; exp[128] = 1'b1;
        run_op(a, b, 1'b0, got, lat, b0);
        checks++;
        if (got !== exp || lat != LAT) begin
            errors++;
            $display("FAIL chunk_carry: lat=%0d low=%h bit128=%0b, want lat=%0d result=2^128",
                     lat, got[191:0], got[128], LAT);
        end

        a = '0; b = '0;
        run_op(a, b, 1'b0, got, lat, b0);
        checks++;
        if (got !== '0 || lat != LAT) begin
            errors++;
            $display("FAIL zero_add: lat=%0d nonzero=%0b, want lat=%0d result=0",
                     lat, got !== '0, LAT);
        end
    endtask

    task automatic test_subtract();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        logic [W:0]   got;
        int           lat;
        logic         b0;

        a = W'(5); b = W'(7);
        if (SUB_EN) begin
            exp = '1; exp[0] = 1'b0;
        end else begin
            exp = (W+1)'(12);
        end
        run_op(a, b, 1'b1, got, lat, b0);
        checks++;
        if (got !== exp || lat != LAT) begin
            errors++;
            $display("FAIL sub_5_7: lat=%0d top=%0b low=%h, want lat=%0d top=%0b low=%h",
                     lat, got[W], got[63:0], LAT, exp[W], exp[63:0]);
        end

        a = W'(7); b = W'(5);
        exp = SUB_EN ? (W+1)'(2) : (W+1)'(12);
        run_op(a, b, 1'b1, got, lat, b0);
        checks++;
        if (got !== exp || lat != LAT) begin
            errors++;
            $display("FAIL sub_7_5: lat=%0d top=%0b low=%h, want lat=%0d top=%0b low=%h",
                     lat, got[W], got[63:0], LAT, exp[W], exp[63:0]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W:0]   exp;
        logic [W:0]   got;
        int           lat;
        logic         b0;

        for (int n = 0; n < 12; n++) begin
            a = rand_wide(); b = rand_wide(); sub = 1'($urandom);
            exp = ref_op(a, b, sub);
            run_op(a, b, sub, got, lat, b0);
            checks++;
            if (got !== exp || lat != LAT || b0 !== 1'b1) begin
                errors++;
                $display("FAIL random_op[%0d] sub=%0b: lat=%0d busy=%0b diffbit=%0d, want lat=%0d busy=1 diffbit=-1",
                         n, sub, lat, b0, first_diff(got, exp), LAT);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
                errors++;
                $display("FAIL random_after_done[%0d]: done=%0b busy=%0b held=%0b, want 0 0 1",
                         n, done, busy, result === exp);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        logic [W:0]   got;
        int           ndone;
        int           first;

        a = rand_wide(); b = rand_wide();
        exp = ref_op(a, b, 1'b0);
        got = '0; ndone = 0; first = 0;
        @(negedge clk);
        in_a = a; in_b = b; subtract = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 2; c <= 25; c++) begin
            @(negedge clk);
            start = (c == 3 || c == 5);
            in_a = rand_wide(); in_b = rand_wide(); subtract = 1'($urandom);
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) begin
                    first = c;
                    got = result;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 1 || first != LAT || got !== exp || result !== exp) begin
            errors++;
            $display("FAIL ignored_start: dones=%0d at=%0d match=%0b held=%0b, want 1 at %0d 1 1",
                     ndone, first, got === exp, result === exp, LAT);
        end
    endtask

    task automatic test_reset_abort();
        logic [W:0] got;
        int         lat;
        int         ndone;
        logic       b0;

        @(negedge clk);
        in_a = '1; in_b = '1; subtract = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: result_nonzero=%0b busy=%0b done=%0b, want 0/0/0",
                     result !== '0, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_no_done: active_cycles=%0d, want 0", ndone);
        end
        run_op(W'(3), W'(4), 1'b0, got, lat, b0);
        checks++;
        if (got !== (W+1)'(7) || lat != LAT) begin
            errors++;
            $display("FAIL after_reset_3_4: lat=%0d low=%h, want lat=%0d low=7",
                     lat, got[63:0], LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        int           lat1;
        int           lat2;

        a = rand_wide(); b = rand_wide();
        exp = ref_op(a, b, 1'b0);
        @(negedge clk);
        in_a = a; in_b = b; subtract = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        in_a = W'(1); in_b = W'(1);
        lat1 = 1;
        while (done !== 1'b1 && lat1 < MAXWAIT) begin
            @(posedge clk); #1;
            lat1++;
        end
        checks++;
        if (lat1 != LAT || result !== exp) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d match=%0b, want lat=%0d match=1",
                     lat1, result === exp, LAT);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_idle: busy=%0b done=%0b, want busy=1 done=0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        lat2 = 1;
        while (done !== 1'b1 && lat2 < MAXWAIT) begin
            @(posedge clk); #1;
            lat2++;
        end
        checks++;
        if (lat2 != LAT || result !== (W+1)'(2)) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d low=%h, want lat=%0d low=2",
                     lat2, result[63:0], LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_subtract();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
